// File: rtl/disp_scan_sched_if.sv
// Bus between the display scheduler and its environment.
//   sw          : raw 2-bit source selector (asynchronous, may bounce)
//   blank       : 1 = all anodes off (synchronous)
//   src0..src3  : 16-bit register taps (a0, v0, sp, ra)
//   an          : anodes, active-low, one-hot-low, an[0] = rightmost digit
//   caths       : cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   frame_start : one-cycle pulse after a new snapshot is taken
//   sel         : currently accepted (debounced) selector
interface disp_scan_sched_if;
    logic [1:0]  sw;
    logic        blank;
    logic [15:0] src0;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [15:0] src3;
    logic [3:0]  an;
    logic [7:0]  caths;
    logic        frame_start;
    logic [1:0]  sel;

    modport master (
        output sw, blank, src0, src1, src2, src3,
        input  an, caths, frame_start, sel
    );

    modport slave (
        input  sw, blank, src0, src1, src2, src3,
        output an, caths, frame_start, sel
    );
endinterface

// File: rtl/disp_scan_sched.sv
// Four-digit seven-segment display scheduler. Picks one of four 16-bit
// sources with a debounced selector, snapshots it at frame boundaries so a
// frame never tears, and scans the four hex digits onto the board pins.
//   clk   : system clock (the scan rate is derived from it)
//   reset : asynchronous, active-low reset
//   bus   : slave side of disp_scan_sched_if (selector, blank, sources in;
//           anodes, cathodes, frame_start, sel out)
module disp_scan_sched #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    disp_scan_sched_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);

    logic [PW-1:0] pcnt;
    logic [1:0]    dig;
    logic [1:0]    sw_meta;
    logic [1:0]    sw_s;
    logic [1:0]    sw_last;
    logic [1:0]    sel_q;
    logic [DW-1:0] deb_cnt;
    logic [15:0]   snap;
    logic [3:0]    an_p1;
    logic [7:0]    caths_p1;
    logic          fs_p1;

    logic          tick;
    logic          frame_edge;
    logic [15:0]   src_cur;
    logic [3:0]    nib;

    function automatic logic [7:0] hexseg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick       = (pcnt == PLAST);
    assign frame_edge = tick && (dig == 2'd3);

    always_comb begin
        src_cur = bus.src0;
        case (sel_q)
            2'd1:    src_cur = bus.src1;
            2'd2:    src_cur = bus.src2;
            2'd3:    src_cur = bus.src3;
            default: src_cur = bus.src0;
        endcase
        nib = snap[{dig, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt     <= '0;
            dig      <= 2'd0;
            sw_meta  <= 2'd0;
            sw_s     <= 2'd0;
            sw_last  <= 2'd0;
            sel_q    <= 2'd0;
            deb_cnt  <= '0;
            snap     <= 16'h0000;
            an_p1    <= 4'b1111;
            caths_p1 <= 8'hFF;
            fs_p1    <= 1'b0;
        end else begin
            // Scan timing: prescaler and digit slot never stall, even when blanked.
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                dig <= dig + 2'd1;
            end

            // Selector: sync, then require DEBOUNCE ticks of a stable new value.
            // sw_last catches a change between two non-selected codes.
            sw_meta <= bus.sw;
            sw_s    <= sw_meta;
            sw_last <= sw_s;
            if ((sw_s == sel_q) || (sw_s != sw_last)) begin
                deb_cnt <= '0;
            end else if (tick) begin
                if (deb_cnt == DLAST) begin
                    sel_q   <= sw_s;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            // Snapshot uses the sel in force this cycle, so a same-cycle
            // acceptance only takes effect at the following frame.
            if (frame_edge) begin
                snap <= src_cur;
            end
            fs_p1 <= frame_edge;

            // Output stage: cathodes stay driven while the anodes are blanked.
            an_p1    <= bus.blank ? 4'b1111 : ~(4'b0001 << dig);
            caths_p1 <= hexseg(nib);
        end
    end

    assign bus.an          = an_p1;
    assign bus.caths       = caths_p1;
    assign bus.frame_start = fs_p1;
    assign bus.sel         = sel_q;
endmodule

// File: tb/tb_disp_scan_sched.sv
// Self-checking bench for disp_scan_sched (SCAN_DIV=4, DEBOUNCE=2).
module tb_disp_scan_sched;
    localparam int SD  = 4;
    localparam int DEB = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    disp_scan_sched_if ifc ();

    disp_scan_sched #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [15:0] src_of(input logic [1:0] s);
        case (s)
            2'd0:    return ifc.src0;
            2'd1:    return ifc.src1;
            2'd2:    return ifc.src2;
            default: return ifc.src3;
        endcase
    endfunction

    // Reference model: time is a cycle index since reset release; slot,
    // digit and frame position follow from it arithmetically. The selector
    // is accepted once DEB ticks have elapsed since sw_s last changed.
    int unsigned m_c   = 0;
    int unsigned m_chg = 0;
    logic [1:0]  m_sw1 = 2'd0;
    logic [1:0]  m_sw2 = 2'd0;
    logic [15:0] m_snap = 16'h0000;
    logic [3:0]  exp_an = 4'hF;
    logic [7:0]  exp_caths = 8'hFF;
    logic        exp_fs = 1'b0;
    logic [1:0]  exp_sel = 2'd0;

    wire [1:0] m_d   = 2'((m_c / SD) % 4);
    wire       m_tk  = ((m_c % SD) == SD - 1);
    wire       m_bnd = ((m_c % (4 * SD)) == 4 * SD - 1);
    int m_tks;
    assign m_tks = int'((m_c + 1) / SD) - int'((m_chg + 1) / SD);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_c <= 0;  m_chg <= 0;  m_sw1 <= 2'd0;  m_sw2 <= 2'd0;  m_snap <= 16'h0;
            exp_an <= 4'hF;  exp_caths <= 8'hFF;  exp_fs <= 1'b0;  exp_sel <= 2'd0;
        end else begin
            m_c       <= m_c + 1;
            exp_an    <= ifc.blank ? 4'hF : ~(4'b0001 << m_d);
            exp_caths <= seg_tab[m_snap[{m_d, 2'b00} +: 4]];
            exp_fs    <= m_bnd;
            if (m_bnd) m_snap <= src_of(exp_sel);
            if (m_tk && (m_sw2 != exp_sel) && (m_tks == DEB)) exp_sel <= m_sw2;
            m_sw1 <= ifc.sw;
            m_sw2 <= m_sw1;
            if (m_sw1 != m_sw2) m_chg <= m_c + 1;
        end
    end

    wire [14:0] got_v = {ifc.an, ifc.caths, ifc.sel, ifc.frame_start};
    wire [14:0] exp_v = {exp_an, exp_caths, exp_sel, exp_fs};

    task automatic test_reset();
        ifc.sw = 2'd0;  ifc.blank = 1'b0;
        ifc.src0 = 16'h1234;  ifc.src1 = 16'h0;  ifc.src2 = 16'h0;  ifc.src3 = 16'h0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (got_v !== {4'hF, 8'hFF, 2'd0, 1'b0}) begin
            n_fail++;  $display("FAIL reset_outputs got %h want %h", got_v, {4'hF, 8'hFF, 2'd0, 1'b0});
        end
        n_checks++;
        if (dut.snap !== 16'h0 || dut.deb_cnt !== '0) begin
            n_fail++;  $display("FAIL reset_state got snap=%h deb=%0d want 0/0", dut.snap, dut.deb_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifc.an !== 4'b1110 || ifc.caths !== 8'hC0) begin
            n_fail++;  $display("FAIL first_out got an=%b caths=%h want 1110/C0", ifc.an, ifc.caths);
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_t [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] ct_t [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        int fs_at = -1;
        for (int i = 0; i < 40 && fs_at < 0; i++) begin
            @(negedge clk);
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL scan_pre c%0d got %h want %h", i, got_v, exp_v); end
            if (ifc.frame_start) fs_at = i;
        end
        n_checks++;
        if (fs_at !== 14) begin n_fail++; $display("FAIL scan_first_fs got %0d want 14", fs_at); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.an !== an_t[i/4] || ifc.caths !== ct_t[i/4]) begin
                n_fail++;
                $display("FAIL scan_frame c%0d got %b/%h want %b/%h", i, ifc.an, ifc.caths, an_t[i/4], ct_t[i/4]);
            end
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL scan_model c%0d got %h want %h", i, got_v, exp_v); end
        end
    endtask

    task automatic test_bounce();
        ifc.sw = 2'd1;
        repeat (SD) begin
            @(negedge clk);
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL bounce_hi got %h want %h", got_v, exp_v); end
        end
        ifc.sw = 2'd0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL bounce_lo c%0d got %h want %h", i, got_v, exp_v); end
        end
        n_checks++;
        if (ifc.sel !== 2'd0 || dut.deb_cnt !== '0) begin
            n_fail++;  $display("FAIL bounce_sel got sel=%0d deb=%0d want 0/0", ifc.sel, dut.deb_cnt);
        end
    endtask

    task automatic test_midframe();
        bit seen = 0;
        ifc.src0 = 16'h0000;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ifc.frame_start) seen = 1;
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ifc.an == 4'b1101) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL mid_wait got timeout want digit1"); end
        ifc.src0 = 16'hFFFF;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.caths !== 8'hC0 || got_v !== exp_v) begin
                n_fail++;  $display("FAIL mid_old c%0d got %h want caths C0 model %h", i, got_v, exp_v);
            end
            if (ifc.frame_start) seen = 1;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.caths !== 8'h8E || got_v !== exp_v) begin
                n_fail++;  $display("FAIL mid_new c%0d got %h want caths 8E model %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_select();
        bit seen = 0;
        ifc.src1 = 16'hBEEF;
        ifc.sw   = 2'd1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL sel_wait c%0d got %h want %h", i, got_v, exp_v); end
            if (ifc.sel == 2'd1) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL sel_accept got sel=%0d want 1", ifc.sel); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL sel_hold c%0d got %h want %h", i, got_v, exp_v); end
            if (ifc.frame_start) seen = 1;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0 || i == 12) begin
                n_checks++;
                if (ifc.caths !== ((i == 0) ? 8'h8E : 8'h83)) begin
                    n_fail++;  $display("FAIL sel_show c%0d got %h want %h", i, ifc.caths, (i == 0) ? 8'h8E : 8'h83);
                end
            end
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL sel_frame c%0d got %h want %h", i, got_v, exp_v); end
        end
    endtask

    task automatic test_blank();
        ifc.blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.an !== 4'b1111 || got_v !== exp_v) begin
                n_fail++;  $display("FAIL blank_on c%0d got %h want an 1111 model %h", i, got_v, exp_v);
            end
        end
        ifc.blank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.an === 4'b1111 || got_v !== exp_v) begin
                n_fail++;  $display("FAIL blank_off c%0d got %h want %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        ifc.src3 = 16'h5A3C;
        ifc.sw   = 2'd3;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ifc.sel == 2'd3 && m_d == 2'd2) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rmid_wait got sel=%0d want 3 at digit 2", ifc.sel); end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (got_v !== {4'hF, 8'hFF, 2'd0, 1'b0} || got_v !== exp_v) begin
            n_fail++;  $display("FAIL rmid_async got %h want %h", got_v, {4'hF, 8'hFF, 2'd0, 1'b0});
        end
        ifc.sw = 2'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifc.an !== 4'b1110 || ifc.caths !== 8'hC0 || dut.snap !== 16'h0) begin
            n_fail++;  $display("FAIL rmid_restart got an=%b caths=%h want 1110/C0", ifc.an, ifc.caths);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL rand c%0d got %h want %h", i, got_v, exp_v); end
            if ($urandom_range(15) == 0) ifc.sw = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) begin
                case ($urandom_range(3))
                    0:       ifc.src0 = 16'($urandom);
                    1:       ifc.src1 = 16'($urandom);
                    2:       ifc.src2 = 16'($urandom);
                    default: ifc.src3 = 16'($urandom);
                endcase
            end
            ifc.blank = ($urandom_range(7) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_bounce();
        test_midframe();
        test_select();
        test_blank();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
